// File: rtl/mips_pipe_pkg.sv
// rtl/mips_pipe_pkg.sv - shared MEM/WB control bit indices, widths and skid FSM states
package mips_pipe_pkg;

  localparam int WB_REGWRITE = 0;
  localparam int WB_MEMTOREG = 1;
  localparam int WB_LINK     = 2;
  localparam int WB_CTRL_W   = 3;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skidState_e;

endpackage

// File: rtl/pipe_skid.sv
// rtl/pipe_skid.sv - two-entry head/skid buffer with valid/ready handshake and flush
// The low CLR_W payload bits are control: zeroed whenever their entry goes invalid.
module pipe_skid
  import mips_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CLR_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  skidState_e       state, stateNext;
  logic [WIDTH-1:0] headQ, headNext;
  logic [WIDTH-1:0] skidQ, skidNext;
  logic             inReadyQ;
  logic             accept, consume;

  assign accept    = in_valid && inReadyQ;
  assign consume   = (state != EMPTY) && out_ready;
  assign in_ready  = inReadyQ;
  assign out_valid = (state != EMPTY);
  assign out_data  = headQ;

  always_comb begin
    stateNext = state;
    headNext  = headQ;
    skidNext  = skidQ;
    case (state)
      EMPTY: begin
        if (accept) begin
          stateNext = ONE;
          headNext  = in_data;
        end
      end
      ONE: begin
        if (accept && consume) begin
          headNext = in_data;
        end else if (accept) begin
          stateNext = TWO;
          skidNext  = in_data;
        end else if (consume) begin
          stateNext = EMPTY;
          headNext[CLR_W-1:0] = '0;
        end
      end
      TWO: begin
        if (consume) begin
          stateNext = ONE;
          headNext  = skidQ;
          skidNext[CLR_W-1:0] = '0;
        end
      end
      default: stateNext = EMPTY;
    endcase
    // Flush drops any accept/consume: data fields keep their old value, control clears.
    if (flush) begin
      stateNext = EMPTY;
      headNext  = {headQ[WIDTH-1:CLR_W], {CLR_W{1'b0}}};
      skidNext  = {skidQ[WIDTH-1:CLR_W], {CLR_W{1'b0}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      headQ    <= '0;
      skidQ    <= '0;
      inReadyQ <= 1'b1;
    end else begin
      state    <= stateNext;
      headQ    <= headNext;
      skidQ    <= skidNext;
      inReadyQ <= (stateNext != TWO);
    end
  end

endmodule

// File: rtl/mem_wb_pipe.sv
// rtl/mem_wb_pipe.sv - MEM/WB stage with skid buffer and write-back mux; MEM_WB_FWD_EN enables forwarding
module mem_wb_pipe
  import mips_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CTRL_W = WB_CTRL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] controlIn,
  input  logic [DATA_W-1:0] pcIn,
  input  logic [DATA_W-1:0] memDataIn,
  input  logic [DATA_W-1:0] aluResultIn,
  input  logic [REG_W-1:0]  destRegIn,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] controlOut,
  output logic [DATA_W-1:0] pcOut,
  output logic [DATA_W-1:0] memDataOut,
  output logic [DATA_W-1:0] aluResultOut,
  output logic [REG_W-1:0]  destRegOut,
  output logic [DATA_W-1:0] wb_data,
  output logic              reg_we,
  output logic              fwd_valid,
  output logic [REG_W-1:0]  fwd_reg,
  output logic [DATA_W-1:0] fwd_data
);

  localparam int PAY_W = REG_W + 3 * DATA_W + CTRL_W;

  logic [PAY_W-1:0] payIn, payOut;

  // Control sits in the low bits so pipe_skid can clear it on invalidation.
  assign payIn = {destRegIn, aluResultIn, memDataIn, pcIn, controlIn};
  assign {destRegOut, aluResultOut, memDataOut, pcOut, controlOut} = payOut;

  pipe_skid #(
    .WIDTH (PAY_W),
    .CLR_W (CTRL_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (payIn),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (payOut)
  );

  always_comb begin
    wb_data = aluResultOut;
    if (controlOut[WB_LINK])
      wb_data = pcOut;
    else if (controlOut[WB_MEMTOREG])
      wb_data = memDataOut;
  end

  assign reg_we = out_valid && controlOut[WB_REGWRITE] && (destRegOut != '0);

`ifdef MEM_WB_FWD_EN
  assign fwd_valid = reg_we;
  assign fwd_reg   = destRegOut;
  assign fwd_data  = wb_data;
`else
  assign fwd_valid = 1'b0;
  assign fwd_reg   = '0;
  assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_mem_wb_pipe.sv
// tb/tb_mem_wb_pipe.sv - directed self-checking bench for mem_wb_pipe
module tb_mem_wb_pipe;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  controlIn;
  logic [31:0] pcIn, memDataIn, aluResultIn;
  logic [4:0]  destRegIn;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  controlOut;
  logic [31:0] pcOut, memDataOut, aluResultOut;
  logic [4:0]  destRegOut;
  logic [31:0] wb_data;
  logic        reg_we;
  logic        fwd_valid;
  logic [4:0]  fwd_reg;
  logic [31:0] fwd_data;

  int tests;
  int fails;

  mem_wb_pipe #(.DATA_W(32), .REG_W(5), .CTRL_W(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .controlIn    (controlIn),
    .pcIn         (pcIn),
    .memDataIn    (memDataIn),
    .aluResultIn  (aluResultIn),
    .destRegIn    (destRegIn),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .controlOut   (controlOut),
    .pcOut        (pcOut),
    .memDataOut   (memDataOut),
    .aluResultOut (aluResultOut),
    .destRegOut   (destRegOut),
    .wb_data      (wb_data),
    .reg_we       (reg_we),
    .fwd_valid    (fwd_valid),
    .fwd_reg      (fwd_reg),
    .fwd_data     (fwd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [2:0] c, input logic [31:0] pc,
                       input logic [31:0] md, input logic [31:0] alu, input logic [4:0] d);
    in_valid    = v;
    controlIn   = c;
    pcIn        = pc;
    memDataIn   = md;
    aluResultIn = alu;
    destRegIn   = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL reset_out_valid got %b exp 0", out_valid);
    end
    tests++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL reset_in_ready got %b exp 1", in_ready);
    end
    tests++;
    if ({controlOut, pcOut, memDataOut, aluResultOut, destRegOut} !== '0) begin
      fails++; $display("FAIL reset_fields got %h %h %h %h %h exp all 0",
                        controlOut, pcOut, memDataOut, aluResultOut, destRegOut);
    end
    tests++;
    if ({wb_data, reg_we, fwd_valid, fwd_reg, fwd_data} !== '0) begin
      fails++; $display("FAIL reset_derived got wb=%h we=%b fv=%b fr=%h fd=%h exp all 0",
                        wb_data, reg_we, fwd_valid, fwd_reg, fwd_data);
    end
  endtask

  task automatic test_stream();
    logic [31:0] alus [3];
    logic [4:0]  dests [3];
    alus  = '{32'h10, 32'h20, 32'h30};
    dests = '{5'd3, 5'd4, 5'd5};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'b001, 32'h1000 + i, 32'hAAAA0000 + i, alus[i], dests[i]);
      step();
      tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
        fails++; $display("FAIL stream_hs[%0d] got ov=%b ir=%b exp 1 1", i, out_valid, in_ready);
      end
      tests++;
      if (aluResultOut !== alus[i] || wb_data !== alus[i] || destRegOut !== dests[i]) begin
        fails++; $display("FAIL stream_data[%0d] got alu=%h wb=%h dest=%0d exp %h %h %0d",
                          i, aluResultOut, wb_data, destRegOut, alus[i], alus[i], dests[i]);
      end
      tests++;
      if (reg_we !== 1'b1) begin
        fails++; $display("FAIL stream_we[%0d] got %b exp 1", i, reg_we);
      end
    end
    drive(1'b0, 3'b000, 0, 0, 0, 0);
    step();
    tests++;
    if (out_valid !== 1'b0 || reg_we !== 1'b0) begin
      fails++; $display("FAIL stream_drain got ov=%b we=%b exp 0 0", out_valid, reg_we);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    drive(1'b1, 3'b001, 0, 0, 32'hA1, 5'd1);
    step();
    tests++;
    if (out_valid !== 1'b1 || in_ready !== 1'b1 || aluResultOut !== 32'hA1) begin
      fails++; $display("FAIL bp_c1 got ov=%b ir=%b alu=%h exp 1 1 a1", out_valid, in_ready, aluResultOut);
    end
    drive(1'b1, 3'b001, 0, 0, 32'hB2, 5'd2);
    step();
    tests++;
    if (in_ready !== 1'b0 || aluResultOut !== 32'hA1) begin
      fails++; $display("FAIL bp_c2 got ir=%b alu=%h exp 0 a1", in_ready, aluResultOut);
    end
    drive(1'b1, 3'b001, 0, 0, 32'hC3, 5'd3);
    step();
    tests++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || aluResultOut !== 32'hA1) begin
      fails++; $display("FAIL bp_c3 got ir=%b ov=%b alu=%h exp 0 1 a1", in_ready, out_valid, aluResultOut);
    end
    // Release: A consumed, B from skid; C is still being offered and lands after B.
    out_ready = 1'b1;
    step();
    tests++;
    if (out_valid !== 1'b1 || aluResultOut !== 32'hB2 || destRegOut !== 5'd2 || in_ready !== 1'b1) begin
      fails++; $display("FAIL bp_drain_b got ov=%b alu=%h dest=%0d ir=%b exp 1 b2 2 1",
                        out_valid, aluResultOut, destRegOut, in_ready);
    end
    step();
    tests++;
    if (out_valid !== 1'b1 || aluResultOut !== 32'hC3 || destRegOut !== 5'd3) begin
      fails++; $display("FAIL bp_drain_c got ov=%b alu=%h dest=%0d exp 1 c3 3",
                        out_valid, aluResultOut, destRegOut);
    end
    drive(1'b0, 3'b000, 0, 0, 0, 0);
    step();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL bp_empty got ov=%b exp 0", out_valid);
    end
  endtask

  task automatic test_mux();
    out_ready = 1'b1;
    drive(1'b1, 3'b011, 32'h00000111, 32'hDEADBEEF, 32'h00000001, 5'd2);
    step();
    tests++;
    if (wb_data !== 32'hDEADBEEF || reg_we !== 1'b1 || controlOut !== 3'b011) begin
      fails++; $display("FAIL mux_mem got wb=%h we=%b ctl=%b exp deadbeef 1 011", wb_data, reg_we, controlOut);
    end
    drive(1'b1, 3'b101, 32'h00400008, 32'h00000077, 32'h00000002, 5'd31);
    step();
    tests++;
    if (wb_data !== 32'h00400008 || reg_we !== 1'b1 || controlOut !== 3'b101) begin
      fails++; $display("FAIL mux_link got wb=%h we=%b ctl=%b exp 00400008 1 101", wb_data, reg_we, controlOut);
    end
    drive(1'b1, 3'b001, 32'h0, 32'h0, 32'h00000099, 5'd0);
    step();
    tests++;
    if (reg_we !== 1'b0 || wb_data !== 32'h99 || out_valid !== 1'b1) begin
      fails++; $display("FAIL mux_r0 got we=%b wb=%h ov=%b exp 0 99 1", reg_we, wb_data, out_valid);
    end
    drive(1'b1, 3'b000, 32'h0, 32'h0, 32'h00000042, 5'd5);
    step();
    tests++;
    if (reg_we !== 1'b0 || wb_data !== 32'h42) begin
      fails++; $display("FAIL mux_nowrite got we=%b wb=%h exp 0 42", reg_we, wb_data);
    end
    drive(1'b0, 3'b000, 0, 0, 0, 0);
    step();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 3'b001, 0, 0, 32'h11, 5'd1);
    step();
    drive(1'b1, 3'b001, 0, 0, 32'h22, 5'd2);
    step();
    flush = 1'b1;
    drive(1'b1, 3'b001, 0, 0, 32'h33, 5'd3);
    step();
    flush = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || reg_we !== 1'b0) begin
      fails++; $display("FAIL flush_two got ov=%b ir=%b we=%b exp 0 1 0", out_valid, in_ready, reg_we);
    end
    // Flush in ONE while an accept is possible: the offered entry is dropped.
    drive(1'b1, 3'b001, 0, 0, 32'h44, 5'd4);
    step();
    flush = 1'b1;
    drive(1'b1, 3'b001, 0, 0, 32'h55, 5'd5);
    step();
    flush = 1'b0;
    drive(1'b0, 3'b000, 0, 0, 0, 0);
    out_ready = 1'b1;
    tests++;
    if (out_valid !== 1'b0 || controlOut !== 3'b000) begin
      fails++; $display("FAIL flush_one got ov=%b ctl=%b exp 0 000", out_valid, controlOut);
    end
    step();
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL flush_after got ov=%b ir=%b exp 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive(1'b1, 3'b111, 32'h5, 32'h6, 32'h7, 5'd8);
    step();
    drive(1'b1, 3'b011, 32'h9, 32'hA, 32'hB, 5'd12);
    step();
    tests++;
    if (in_ready !== 1'b0) begin
      fails++; $display("FAIL rstmid_pre got ir=%b exp 0", in_ready);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(1'b0, 3'b000, 0, 0, 0, 0);
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL rstmid_hs got ov=%b ir=%b exp 0 1", out_valid, in_ready);
    end
    tests++;
    if ({controlOut, pcOut, memDataOut, aluResultOut, destRegOut, wb_data, reg_we} !== '0) begin
      fails++; $display("FAIL rstmid_fields got ctl=%b pc=%h md=%h alu=%h d=%0d wb=%h we=%b exp all 0",
                        controlOut, pcOut, memDataOut, aluResultOut, destRegOut, wb_data, reg_we);
    end
    step();
  endtask

  task automatic test_fwd();
    logic        expValid;
    logic [4:0]  expReg;
    logic [31:0] expData;
`ifdef MEM_WB_FWD_EN
    expValid = 1'b1; expReg = 5'd7; expData = 32'h55;
`else
    expValid = 1'b0; expReg = 5'd0; expData = 32'h0;
`endif
    out_ready = 1'b1;
    drive(1'b1, 3'b001, 32'h0, 32'h0, 32'h55, 5'd7);
    step();
    tests++;
    if (fwd_valid !== expValid || fwd_reg !== expReg || fwd_data !== expData) begin
      fails++; $display("FAIL fwd_head got %b %0d %h exp %b %0d %h",
                        fwd_valid, fwd_reg, fwd_data, expValid, expReg, expData);
    end
    drive(1'b0, 3'b000, 0, 0, 0, 0);
    step();
    tests++;
    if (fwd_valid !== 1'b0) begin
      fails++; $display("FAIL fwd_idle got %b exp 0", fwd_valid);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 3'b000, 0, 0, 0, 0);
    test_reset();
    test_stream();
    test_back_to_back();
    test_mux();
    test_flush();
    test_reset_mid();
    test_fwd();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
